// File: rtl/hid_pkg.sv
// Shared definitions for the CPC keyboard matrix input path.
package hid_pkg;

    localparam int ROWS_DEF  = 16;
    localparam int COLS_DEF  = 8;
    localparam int ROW_W_DEF = $clog2(ROWS_DEF);
    localparam int COL_W_DEF = $clog2(COLS_DEF);

    // CPC matrix positions of the modifier keys
    localparam int CPC_SHIFT_ROW = 2;
    localparam int CPC_SHIFT_COL = 5;
    localparam int CPC_CTRL_ROW  = 2;
    localparam int CPC_CTRL_COL  = 7;

    // Matrix coordinate and injection entry in the default CPC geometry
    typedef struct packed {
        logic [ROW_W_DEF-1:0] row;
        logic [COL_W_DEF-1:0] col;
    } key_pos_t;

    typedef struct packed {
        key_pos_t pos;
        logic     shift;
    } inj_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETUP   = 2'd1,
        ST_PRESS   = 2'd2,
        ST_RELEASE = 2'd3
    } inj_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/inj_fifo.sv
// Type-in injection FIFO: head is read combinationally, flush empties it
// and drops any write offered in the same cycle.
module inj_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
    localparam logic [AW:0]   DEPTH_L = (AW + 1)'(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
    logic [AW-1:0]               wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]               rd_ptr_q, rd_ptr_d;
    logic [AW:0]                 count_q, count_d;
    logic                        do_push_s, do_pop_s;

    assign do_push_s = push && (count_q < DEPTH_L);
    assign do_pop_s  = pop && (count_q != '0);
    assign rdata     = mem_q[rd_ptr_q];
    assign count     = count_q;

    // Next-state for storage, pointers and occupancy
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push_s) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // FIFO state registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/hid_matrix_inject.sv
// Keyboard matrix merging live key events with a timed type-in injector.
// The scan reads X = ~(live | inj) for the selected row Y.
module hid_matrix_inject
    import hid_pkg::*;
#(
    parameter int ROWS      = ROWS_DEF,
    parameter int COLS      = COLS_DEF,
    parameter int DEPTH     = 16,
    parameter int HOLD      = 4,
    parameter int GAP       = 2,
    parameter int TIMEBASE  = 0,
    parameter int SYNC_ROW  = 9,
    parameter int SHIFT_ROW = CPC_SHIFT_ROW,
    parameter int SHIFT_COL = CPC_SHIFT_COL
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    key_strobe,
    input  logic                    key_pressed,
    input  logic [$clog2(ROWS)-1:0] key_row,
    input  logic [$clog2(COLS)-1:0] key_col,
    input  logic                    key_clear,
    input  logic                    inj_valid,
    output logic                    inj_ready,
    input  logic [$clog2(ROWS)-1:0] inj_row,
    input  logic [$clog2(COLS)-1:0] inj_col,
    input  logic                    inj_shift,
    input  logic                    inj_flush,
    input  logic [3:0]              Y,
    output logic [COLS-1:0]         X,
    output logic                    busy
);

    localparam int RW    = $clog2(ROWS);
    localparam int CW    = $clog2(COLS);
    localparam int EW    = RW + CW + 1;
    localparam int FCW   = $clog2(DEPTH) + 1;
    localparam int CNT_W = $clog2(max_int(HOLD, GAP) + 1);

    localparam logic [CNT_W-1:0] HOLD_C  = CNT_W'(HOLD);
    localparam logic [CNT_W-1:0] GAP_C   = CNT_W'(GAP);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [RW:0]      ROWS_L  = (RW + 1)'(ROWS);
    localparam logic [FCW-1:0]   DEPTH_L = FCW'(DEPTH);
    localparam logic [3:0]       SYNC_Y  = 4'(SYNC_ROW);

    // Injection entry in this instance's geometry (row, col, shift; MSB first)
    typedef struct packed {
        logic [RW-1:0] row;
        logic [CW-1:0] col;
    } pos_t;

    typedef struct packed {
        pos_t pos;
        logic shift;
    } entry_t;

    logic [ROWS-1:0][COLS-1:0] live_q, live_d;
    logic [ROWS-1:0][COLS-1:0] inj_q, inj_d;
    inj_state_t                state_q, state_d;
    entry_t                    cur_q, cur_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      first_q, first_d;
    logic [3:0]                y_q, y_d;

    entry_t                    inj_entry_s;
    entry_t                    fifo_rdata_s;
    logic [FCW-1:0]            fifo_count_s;
    logic                      push_s, pop_s;
    logic                      sync_edge_s, tick_s, unit_done_s;
    logic                      cur_row_ok_s;
    logic [COLS-1:0]           row_sel_s;

    assign inj_entry_s = {inj_row, inj_col, inj_shift};
    assign inj_ready   = (fifo_count_s < DEPTH_L);
    assign push_s      = inj_valid && inj_ready;
    assign busy        = (state_q != ST_IDLE) || (fifo_count_s != '0);

    inj_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (inj_flush),
        .push    (push_s),
        .pop     (pop_s),
        .wdata   (inj_entry_s),
        .rdata   (fifo_rdata_s),
        .count   (fifo_count_s)
    );

    // A scan unit is the cycle where Y newly selects SYNC_ROW; the entry
    // cycle of a state never counts so a unit always spans a full scan.
    assign y_d         = Y;
    assign sync_edge_s = (Y == SYNC_Y) && (y_q != SYNC_Y);
    assign tick_s      = (TIMEBASE == 0) ? 1'b1 : (sync_edge_s && !first_q);
    assign unit_done_s = tick_s && (cnt_q == CNT_ONE);

    // Live matrix update; clear beats a same-cycle strobe
    always_comb begin
        live_d = live_q;
        if (key_clear) begin
            live_d = '0;
        end else if (key_strobe && ({1'b0, key_row} < ROWS_L)) begin
            live_d[key_row][key_col] = key_pressed;
        end else begin
            live_d = live_q;
        end
    end

    // Injection sequencer: pop, optional shift setup, press, release gap
    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        cnt_d   = cnt_q;
        first_d = 1'b0;
        pop_s   = 1'b0;
        if (inj_flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (fifo_count_s != '0) begin
                        pop_s   = 1'b1;
                        cur_d   = fifo_rdata_s;
                        first_d = 1'b1;
                        if (fifo_rdata_s.shift) begin
                            state_d = ST_SETUP;
                            cnt_d   = GAP_C;
                        end else begin
                            state_d = ST_PRESS;
                            cnt_d   = HOLD_C;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_SETUP: begin
                    if (unit_done_s) begin
                        state_d = ST_PRESS;
                        cnt_d   = HOLD_C;
                        first_d = 1'b1;
                    end else if (tick_s) begin
                        cnt_d = cnt_q - CNT_ONE;
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
                ST_PRESS: begin
                    if (unit_done_s) begin
                        state_d = ST_RELEASE;
                        cnt_d   = GAP_C;
                        first_d = 1'b1;
                    end else if (tick_s) begin
                        cnt_d = cnt_q - CNT_ONE;
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
                ST_RELEASE: begin
                    if (unit_done_s) begin
                        state_d = ST_IDLE;
                    end else if (tick_s) begin
                        cnt_d = cnt_q - CNT_ONE;
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Injected keys follow the next state so inj_q lines up with state_q
    assign cur_row_ok_s = ({1'b0, cur_d.pos.row} < ROWS_L);

    // Decode the injection matrix from the upcoming state
    always_comb begin
        inj_d = '0;
        case (state_d)
            ST_SETUP: begin
                inj_d[SHIFT_ROW][SHIFT_COL] = 1'b1;
            end
            ST_PRESS: begin
                inj_d[SHIFT_ROW][SHIFT_COL] = cur_d.shift;
                inj_d[cur_d.pos.row][cur_d.pos.col] =
                    inj_d[cur_d.pos.row][cur_d.pos.col] | cur_row_ok_s;
            end
            default: begin
                inj_d = '0;
            end
        endcase
    end

    // Row read mux; rows outside the matrix read as released
    always_comb begin
        row_sel_s = '0;
        for (int r = 0; r < ROWS; r++) begin
            row_sel_s = row_sel_s |
                (({28'd0, Y} == 32'(r)) ? (live_q[r] | inj_q[r]) : {COLS{1'b0}});
        end
    end

    assign X = ~row_sel_s;

    // Matrix, sequencer and scan-edge registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            live_q  <= '0;
            inj_q   <= '0;
            state_q <= ST_IDLE;
            cur_q   <= '0;
            cnt_q   <= '0;
            first_q <= 1'b0;
            y_q     <= '0;
        end else begin
            live_q  <= live_d;
            inj_q   <= inj_d;
            state_q <= state_d;
            cur_q   <= cur_d;
            cnt_q   <= cnt_d;
            first_q <= first_d;
            y_q     <= y_d;
        end
    end

endmodule

// File: tb/tb_hid_matrix_inject.sv
// Directed bench: live matrix table, cycle-exact injection sequences,
// flush, scan-timed units, FIFO fill/replay order and async reset.
`timescale 1ns/1ps
module tb_hid_matrix_inject;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n;
    // cycle-timebase instance
    logic       key_strobe, key_pressed, key_clear;
    logic [3:0] key_row;
    logic [2:0] key_col;
    logic       inj_valid, inj_ready, inj_shift, inj_flush;
    logic [3:0] inj_row;
    logic [2:0] inj_col;
    logic [3:0] y;
    logic [7:0] x;
    logic       busy;
    // scan-timebase instance
    logic       t1_key_strobe, t1_key_pressed, t1_key_clear;
    logic [3:0] t1_key_row;
    logic [2:0] t1_key_col;
    logic       t1_inj_valid, t1_inj_ready, t1_inj_shift, t1_inj_flush;
    logic [3:0] t1_inj_row;
    logic [2:0] t1_inj_col;
    logic [3:0] t1_y;
    logic [7:0] t1_x;
    logic       t1_busy;

    int vec_cnt = 0;
    int err_cnt = 0;

    hid_matrix_inject #(.HOLD(4), .GAP(2), .TIMEBASE(0)) dut0 (
        .clk(clk), .reset_n(reset_n),
        .key_strobe(key_strobe), .key_pressed(key_pressed),
        .key_row(key_row), .key_col(key_col), .key_clear(key_clear),
        .inj_valid(inj_valid), .inj_ready(inj_ready),
        .inj_row(inj_row), .inj_col(inj_col), .inj_shift(inj_shift),
        .inj_flush(inj_flush), .Y(y), .X(x), .busy(busy)
    );

    hid_matrix_inject #(.HOLD(4), .GAP(2), .TIMEBASE(1), .SYNC_ROW(9)) dut1 (
        .clk(clk), .reset_n(reset_n),
        .key_strobe(t1_key_strobe), .key_pressed(t1_key_pressed),
        .key_row(t1_key_row), .key_col(t1_key_col), .key_clear(t1_key_clear),
        .inj_valid(t1_inj_valid), .inj_ready(t1_inj_ready),
        .inj_row(t1_inj_row), .inj_col(t1_inj_col), .inj_shift(t1_inj_shift),
        .inj_flush(t1_inj_flush), .Y(t1_y), .X(t1_x), .busy(t1_busy)
    );

    typedef struct {
        logic       strobe;
        logic       pressed;
        logic [3:0] row;
        logic [2:0] col;
        logic       clear;
        logic [3:0] yy;
        logic [7:0] exp_x;
    } live_vec_t;

    live_vec_t lv[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp_a[8];
        logic       exp_ab[8];
        logic [7:0] exp_r2[10];
        logic [7:0] exp_r3[10];
        logic       hist[$];
        logic [6:0] rec[$];
        logic [6:0] exp_key[17];
        logic [6:0] cur_key;
        logic [2:0] zcol;
        logic       seen_ready;
        int         dwell;

        reset_n = 1'b0;
        key_strobe = 1'b0; key_pressed = 1'b0; key_row = 4'd0; key_col = 3'd0; key_clear = 1'b0;
        inj_valid = 1'b0; inj_row = 4'd0; inj_col = 3'd0; inj_shift = 1'b0; inj_flush = 1'b0;
        y = 4'd0;
        t1_key_strobe = 1'b0; t1_key_pressed = 1'b0; t1_key_row = 4'd0; t1_key_col = 3'd0;
        t1_key_clear = 1'b0; t1_inj_valid = 1'b0; t1_inj_row = 4'd0; t1_inj_col = 3'd0;
        t1_inj_shift = 1'b0; t1_inj_flush = 1'b0; t1_y = 4'd0;

        // ---- reset state
        #12;
        check("rst_ready", inj_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_x", x, 8'hFF);
        #10 reset_n = 1'b1;
        tick();

        // ---- live matrix table
        lv[0]  = '{1'b1, 1'b1, 4'd4,  3'd2, 1'b0, 4'd4,  8'hFB};
        lv[1]  = '{1'b0, 1'b0, 4'd0,  3'd0, 1'b0, 4'd12, 8'hFF};
        lv[2]  = '{1'b1, 1'b1, 4'd4,  3'd7, 1'b0, 4'd4,  8'h7B};
        lv[3]  = '{1'b1, 1'b0, 4'd4,  3'd2, 1'b0, 4'd4,  8'h7F};
        lv[4]  = '{1'b1, 1'b1, 4'd0,  3'd0, 1'b0, 4'd0,  8'hFE};
        lv[5]  = '{1'b1, 1'b1, 4'd1,  3'd1, 1'b1, 4'd1,  8'hFF};
        lv[6]  = '{1'b0, 1'b0, 4'd0,  3'd0, 1'b0, 4'd4,  8'hFF};
        lv[7]  = '{1'b0, 1'b0, 4'd0,  3'd0, 1'b0, 4'd0,  8'hFF};
        lv[8]  = '{1'b1, 1'b1, 4'd15, 3'd7, 1'b0, 4'd15, 8'h7F};
        lv[9]  = '{1'b0, 1'b0, 4'd0,  3'd0, 1'b0, 4'd12, 8'hFF};
        lv[10] = '{1'b1, 1'b0, 4'd15, 3'd7, 1'b0, 4'd15, 8'hFF};
        for (int i = 0; i < 11; i++) begin
            key_strobe = lv[i].strobe; key_pressed = lv[i].pressed;
            key_row = lv[i].row; key_col = lv[i].col; key_clear = lv[i].clear;
            tick();
            key_strobe = 1'b0; key_clear = 1'b0;
            y = lv[i].yy;
            #1;
            check($sformatf("live[%0d]", i), x, lv[i].exp_x);
        end

        // ---- plain injection: 1 pop cycle, 4 press, 2 release
        exp_a  = '{8'hFF, 8'hDF, 8'hDF, 8'hDF, 8'hDF, 8'hFF, 8'hFF, 8'hFF};
        exp_ab = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        y = 4'd8;
        inj_valid = 1'b1; inj_row = 4'd8; inj_col = 3'd5; inj_shift = 1'b0;
        tick();
        inj_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            #1;
            check($sformatf("injA_x[%0d]", k), x, exp_a[k]);
            check($sformatf("injA_busy[%0d]", k), busy, exp_ab[k]);
            tick();
        end

        // ---- shifted injection: shift alone, then shift+key, then none
        exp_r2 = '{8'hFF, 8'hDF, 8'hDF, 8'hDF, 8'hDF, 8'hDF, 8'hDF, 8'hFF, 8'hFF, 8'hFF};
        exp_r3 = '{8'hFF, 8'hFF, 8'hFF, 8'hF7, 8'hF7, 8'hF7, 8'hF7, 8'hFF, 8'hFF, 8'hFF};
        inj_valid = 1'b1; inj_row = 4'd3; inj_col = 3'd3; inj_shift = 1'b1;
        tick();
        inj_valid = 1'b0; inj_shift = 1'b0;
        for (int k = 0; k < 10; k++) begin
            y = 4'd2;
            #1;
            check($sformatf("injS_row2[%0d]", k), x, exp_r2[k]);
            y = 4'd3;
            #1;
            check($sformatf("injS_row3[%0d]", k), x, exp_r3[k]);
            tick();
        end
        check("injS_busy_end", busy, 0);

        // ---- flush during PRESS with the same key held live
        y = 4'd8;
        key_strobe = 1'b1; key_pressed = 1'b1; key_row = 4'd8; key_col = 3'd5;
        inj_valid = 1'b1; inj_row = 4'd8; inj_col = 3'd5; inj_shift = 1'b0;
        tick();
        key_strobe = 1'b0; inj_valid = 1'b0;
        tick();
        tick();
        #1;
        check("flush_pre_x", x, 8'hDF);
        check("flush_pre_busy", busy, 1);
        inj_flush = 1'b1;
        inj_valid = 1'b1; inj_row = 4'd6; inj_col = 3'd1;
        tick();
        inj_flush = 1'b0; inj_valid = 1'b0;
        #1;
        check("flush_live_x", x, 8'hDF);
        check("flush_busy", busy, 0);
        check("flush_ready", inj_ready, 1);
        key_strobe = 1'b1; key_pressed = 1'b0; key_row = 4'd8; key_col = 3'd5;
        tick();
        key_strobe = 1'b0;
        #1;
        check("flush_inj_gone", x, 8'hFF);
        tick();
        tick();
        y = 4'd6;
        #1;
        check("flush_drop_x", x, 8'hFF);
        check("flush_drop_busy", busy, 0);

        // ---- scan timebase: PRESS spans exactly 4 SYNC_ROW entries
        t1_y = 4'd0;
        t1_inj_valid = 1'b1; t1_inj_row = 4'd9; t1_inj_col = 3'd4; t1_inj_shift = 1'b0;
        tick();
        t1_inj_valid = 1'b0;
        tick();
        tick();
        for (int s = 0; s < 8; s++) begin
            dwell = (s % 2 == 0) ? 1 : 3;
            for (int yv = 0; yv < 10; yv++) begin
                for (int d = 0; d < dwell; d++) begin
                    t1_y = 4'(yv);
                    #1;
                    if (yv == 9 && d == 0) hist.push_back(~t1_x[4]);
                    tick();
                end
            end
        end
        check("tb_hist_len", hist.size(), 8);
        for (int i = 0; i < hist.size(); i++) begin
            check($sformatf("tb_press[%0d]", i), hist[i], (i < 4) ? 1 : 0);
        end
        #1;
        check("tb_busy_end", t1_busy, 0);

        // ---- fill FIFO behind a stalled key, then replay in order
        t1_y = 4'd0;
        exp_key[0] = {4'd15, 3'd7};
        for (int k = 1; k < 17; k++) exp_key[k] = {4'(k - 1), 3'((3 * k) % 8)};
        t1_inj_valid = 1'b1; t1_inj_row = 4'd15; t1_inj_col = 3'd7;
        tick();
        t1_inj_valid = 1'b0;
        tick();
        for (int k = 1; k < 17; k++) begin
            t1_inj_valid = 1'b1;
            t1_inj_row = exp_key[k][6:3];
            t1_inj_col = exp_key[k][2:0];
            #1;
            if (k == 1 || k == 16) check($sformatf("fill_ready_pre[%0d]", k), t1_inj_ready, 1);
            tick();
        end
        t1_inj_row = 4'd9; t1_inj_col = 3'd4;
        #1;
        check("fill_full", t1_inj_ready, 0);
        tick();
        tick();
        t1_inj_valid = 1'b0;
        #1;
        check("fill_still_full", t1_inj_ready, 0);
        seen_ready = 1'b0;
        for (int c = 0; c < 5000; c++) begin
            t1_y = 4'(c % 16);
            #1;
            if (t1_inj_ready) seen_ready = 1'b1;
            if (t1_x != 8'hFF) begin
                zcol = 3'd0;
                for (int b = 7; b >= 0; b--) if (!t1_x[b]) zcol = 3'(b);
                cur_key = {t1_y, zcol};
                if (rec.size() == 0 || rec[rec.size() - 1] != cur_key) rec.push_back(cur_key);
            end
            if (rec.size() >= 17 && !t1_busy) break;
            tick();
        end
        check("fill_ready_back", seen_ready, 1);
        check("fill_count", rec.size(), 17);
        for (int i = 0; i < 17; i++) begin
            if (i < rec.size()) check($sformatf("fill_order[%0d]", i), rec[i], exp_key[i]);
            else check($sformatf("fill_order[%0d]", i), 7'h7F, exp_key[i]);
        end
        check("fill_busy_end", t1_busy, 0);
        tick();

        // ---- asynchronous reset in the middle of PRESS
        y = 4'd8;
        inj_valid = 1'b1; inj_row = 4'd8; inj_col = 3'd5; inj_shift = 1'b0;
        tick();
        inj_valid = 1'b0;
        tick();
        tick();
        #1;
        check("arst_pre_x", x, 8'hDF);
        #1 reset_n = 1'b0;
        #1;
        check("arst_x", x, 8'hFF);
        check("arst_busy", busy, 0);
        check("arst_ready", inj_ready, 1);
        #1 reset_n = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
